// File: rtl/mem_arbiter_if.sv
// Shared types and the bus interface for the processor-memory port arbiter.
//
// mem_arbiter_pkg : address, block, tag and command types. The tag width is
//                   derived from `NUM_MEM_TAGS (defaults to 15 when the
//                   surrounding build has not defined it). Tags are 1-based;
//                   tag 0 means none/reject.
// mem_arbiter_if  : groups the fetch request, dcache request, memory command,
//                   memory response and routed-tag signals.
//   modport slave  : the arbiter side (takes requests and memory responses,
//                    drives the memory command, grants and routed tags).
//   modport master : the environment side (fetch, dcache and memory models).

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_arbiter_pkg;
    localparam int TAG_W = $clog2(`NUM_MEM_TAGS + 1);

    typedef logic [31:0]      ADDR;
    typedef logic [63:0]      MEM_BLOCK;
    typedef logic [TAG_W-1:0] MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MEM_COMMAND;
endpackage

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Requesters
    logic       fetch_req_en;
    ADDR        fetch_addr;
    logic       dc_req_en;
    MEM_COMMAND dc_command;
    ADDR        dc_addr;
    MEM_BLOCK   dc_store_data;
    logic       fetch_flush;

    // Memory side
    MEM_TAG     mem_transaction_tag;
    MEM_TAG     mem_data_tag;
    MEM_BLOCK   mem_data;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;

    // Results back to the requesters
    logic       fetch_grant;
    logic       dc_grant;
    MEM_TAG     fetch_transaction_tag;
    MEM_TAG     dc_transaction_tag;
    MEM_TAG     fetch_data_tag;
    MEM_TAG     dc_data_tag;
    MEM_BLOCK   resp_data;

    modport slave (
        input  fetch_req_en, fetch_addr, dc_req_en, dc_command, dc_addr,
               dc_store_data, fetch_flush, mem_transaction_tag, mem_data_tag,
               mem_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data, fetch_grant,
               dc_grant, fetch_transaction_tag, dc_transaction_tag,
               fetch_data_tag, dc_data_tag, resp_data
    );

    modport master (
        output fetch_req_en, fetch_addr, dc_req_en, dc_command, dc_addr,
               dc_store_data, fetch_flush, mem_transaction_tag, mem_data_tag,
               mem_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data, fetch_grant,
               dc_grant, fetch_transaction_tag, dc_transaction_tag,
               fetch_data_tag, dc_data_tag, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single processor-memory port between instruction fetch
// and the data cache.
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   arb_if       : mem_arbiter_if.slave (requests, memory command/response,
//                  grants, accept tags, routed response tags, resp_data)
//   Optional (MEM_ARB_STATS_EN defined):
//     fetch_grants_cnt, dc_grants_cnt, stale_drop_cnt : 32-bit wrapping
//     counters of accepted fetch requests, accepted dcache requests and
//     silently consumed stale responses.
//
// Grants are combinational. The dcache wins by default; after STARVE_LIMIT
// consecutive cycles of unaccepted fetch requests, fetch wins. A per-tag
// ownership table steers memory responses back to the requester that issued
// the load; fetch_flush marks every outstanding fetch load stale so its
// response is swallowed.

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MEM_TAGS = `NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    mem_arbiter_if.slave arb_if
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] fetch_grants_cnt,
    output logic [31:0] dc_grants_cnt,
    output logic [31:0] stale_drop_cnt
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]         starve_q, starve_d;
    // owner: 0 = fetch, 1 = dcache
    logic [NUM_MEM_TAGS:1] busy_q, busy_d;
    logic [NUM_MEM_TAGS:1] owner_q, owner_d;
    logic [NUM_MEM_TAGS:1] stale_q, stale_d;

    logic                  fetch_pri, fetch_gnt, dc_gnt;
    logic                  fetch_acc, dc_acc, load_acc;
    logic [NUM_MEM_TAGS:1] resp_sel, alloc_sel;
    logic                  resp_hit, resp_owner, resp_stale;

    // One-hot decodes of the response and accept tags; tag 0 selects nothing.
    always_comb begin
        resp_sel  = '0;
        alloc_sel = '0;
        for (int i = 1; i <= NUM_MEM_TAGS; i++) begin
            resp_sel[i]  = (arb_if.mem_data_tag == MEM_TAG'(i));
            alloc_sel[i] = (arb_if.mem_transaction_tag == MEM_TAG'(i));
        end
    end

    // Lookups use the current (old) entry, so a tag freed and reallocated in
    // the same cycle still routes its response to the previous owner.
    assign resp_hit   = |(resp_sel & busy_q);
    assign resp_owner = |(resp_sel & owner_q);
    assign resp_stale = |(resp_sel & stale_q);

    assign fetch_pri = arb_if.fetch_req_en && (int'(starve_q) >= STARVE_LIMIT);
    assign fetch_gnt = arb_if.fetch_req_en && (fetch_pri || !arb_if.dc_req_en);
    assign dc_gnt    = arb_if.dc_req_en && !fetch_gnt;
    assign fetch_acc = fetch_gnt && (arb_if.mem_transaction_tag != '0);
    assign dc_acc    = dc_gnt && (arb_if.mem_transaction_tag != '0);
    assign load_acc  = fetch_acc || (dc_acc && arb_if.dc_command == MEM_LOAD);

    // Port mux and response routing
    always_comb begin
        arb_if.proc2mem_command      = MEM_NONE;
        arb_if.proc2mem_addr         = '0;
        arb_if.proc2mem_data         = '0;
        arb_if.fetch_transaction_tag = '0;
        arb_if.dc_transaction_tag    = '0;
        if (fetch_gnt) begin
            arb_if.proc2mem_command      = MEM_LOAD;
            arb_if.proc2mem_addr         = arb_if.fetch_addr;
            arb_if.fetch_transaction_tag = arb_if.mem_transaction_tag;
        end else if (dc_gnt) begin
            arb_if.proc2mem_command   = arb_if.dc_command;
            arb_if.proc2mem_addr      = arb_if.dc_addr;
            arb_if.proc2mem_data      = arb_if.dc_store_data;
            arb_if.dc_transaction_tag = arb_if.mem_transaction_tag;
        end
    end

    assign arb_if.fetch_grant    = fetch_gnt;
    assign arb_if.dc_grant       = dc_gnt;
    assign arb_if.fetch_data_tag = (resp_hit && !resp_stale && !resp_owner) ? arb_if.mem_data_tag : '0;
    assign arb_if.dc_data_tag    = (resp_hit && !resp_stale &&  resp_owner) ? arb_if.mem_data_tag : '0;
    assign arb_if.resp_data      = arb_if.mem_data;

    // Next state: starvation counter and ownership table
    always_comb begin
        starve_d = starve_q;
        if (arb_if.fetch_flush || !arb_if.fetch_req_en || fetch_acc) begin
            starve_d = '0;
        end else if (int'(starve_q) < STARVE_LIMIT) begin
            starve_d = starve_q + SW'(1);
        end

        // Any response to a busy tag retires it, whatever its state.
        busy_d  = busy_q & ~resp_sel;
        stale_d = stale_q & ~resp_sel;
        owner_d = owner_q;

        if (arb_if.fetch_flush) begin
            stale_d = stale_d | (busy_d & ~owner_d);
        end

        // Allocation is applied last so it overrides a same-tag retirement.
        if (load_acc) begin
            busy_d = busy_d | alloc_sel;
            if (dc_acc) begin
                owner_d = owner_d | alloc_sel;
            end else begin
                owner_d = owner_d & ~alloc_sel;
            end
            if (fetch_acc && arb_if.fetch_flush) begin
                stale_d = stale_d | alloc_sel;
            end else begin
                stale_d = stale_d & ~alloc_sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
            busy_q   <= '0;
            owner_q  <= '0;
            stale_q  <= '0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            stale_q  <= stale_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] fetch_cnt_q, dc_cnt_q, drop_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            dc_cnt_q    <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (fetch_acc)               fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (dc_acc)                  dc_cnt_q    <= dc_cnt_q + 32'd1;
            if (resp_hit && resp_stale)  drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
    end

    assign fetch_grants_cnt = fetch_cnt_q;
    assign dc_grants_cnt    = dc_cnt_q;
    assign stale_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] fetch_grants_cnt, dc_grants_cnt, stale_drop_cnt;
`endif

    mem_arbiter #(.NUM_MEM_TAGS(`NUM_MEM_TAGS), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .arb_if(bus.slave)
`ifdef MEM_ARB_STATS_EN
        ,
        .fetch_grants_cnt(fetch_grants_cnt),
        .dc_grants_cnt   (dc_grants_cnt),
        .stale_drop_cnt  (stale_drop_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        // inputs
        logic       fr;
        ADDR        fa;
        logic       dr;
        MEM_COMMAND dcmd;
        ADDR        da;
        MEM_BLOCK   dd;
        logic       fl;
        MEM_TAG     tt;
        MEM_TAG     dt;
        // expected outputs
        logic       efg;
        logic       edg;
        MEM_COMMAND ecmd;
        ADDR        eaddr;
        MEM_BLOCK   edata;
        MEM_TAG     eftt;
        MEM_TAG     edtt;
        MEM_TAG     efdt;
        MEM_TAG     eddt;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];
    int   step_no = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational outputs mid-cycle,
    // then let the edge commit. Called at posedge+1.
    task automatic step(input vec_t v, input string nm);
        MEM_BLOCK md;
        md = {32'hC0DE_0000, 32'(step_no)};
        step_no++;
        bus.fetch_req_en        = v.fr;
        bus.fetch_addr          = v.fa;
        bus.dc_req_en           = v.dr;
        bus.dc_command          = v.dcmd;
        bus.dc_addr             = v.da;
        bus.dc_store_data       = v.dd;
        bus.fetch_flush         = v.fl;
        bus.mem_transaction_tag = v.tt;
        bus.mem_data_tag        = v.dt;
        bus.mem_data            = md;
        @(negedge clock);
        chk({nm, ".fetch_grant"}, 64'(bus.fetch_grant), 64'(v.efg));
        chk({nm, ".dc_grant"},    64'(bus.dc_grant),    64'(v.edg));
        chk({nm, ".command"},     64'(bus.proc2mem_command), 64'(v.ecmd));
        chk({nm, ".addr"},        64'(bus.proc2mem_addr), 64'(v.eaddr));
        chk({nm, ".data"},        bus.proc2mem_data, v.edata);
        chk({nm, ".fetch_ttag"},  64'(bus.fetch_transaction_tag), 64'(v.eftt));
        chk({nm, ".dc_ttag"},     64'(bus.dc_transaction_tag), 64'(v.edtt));
        chk({nm, ".fetch_dtag"},  64'(bus.fetch_data_tag), 64'(v.efdt));
        chk({nm, ".dc_dtag"},     64'(bus.dc_data_tag), 64'(v.eddt));
        chk({nm, ".resp_data"},   bus.resp_data, md);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        //                fr  fa        dr  dcmd       da        dd          fl  tt  dt   | fg  dg  cmd        addr      data        ftt dtt fdt ddt
        idle    = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 0,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 0};
        // basic fetch load and its response
        tbl[0]  = idle;
        tbl[1]  = '{1'b1, 32'h100, 1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 3, 0,   1'b1, 1'b0, MEM_LOAD,  32'h100, 64'h0,     3, 0, 0, 0};
        tbl[2]  = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 3,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 3, 0};
        tbl[3]  = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 3,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 0};
        // store allocates nothing
        tbl[4]  = '{1'b0, 32'h0,   1'b1, MEM_STORE, 32'h200, 64'hDEAD,  1'b0, 5, 0,   1'b0, 1'b1, MEM_STORE, 32'h200, 64'hDEAD,  0, 5, 0, 0};
        tbl[5]  = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 5,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 0};
        // flushed fetch load, then tag reused by dcache
        tbl[6]  = '{1'b1, 32'h104, 1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 2, 0,   1'b1, 1'b0, MEM_LOAD,  32'h104, 64'h0,     2, 0, 0, 0};
        tbl[7]  = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b1, 0, 0,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 0};
        tbl[8]  = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 2,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 0};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, MEM_LOAD,  32'h300, 64'h55,    1'b0, 2, 0,   1'b0, 1'b1, MEM_LOAD,  32'h300, 64'h55,    0, 2, 0, 0};
        tbl[10] = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 2,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 2};
        // rejected fetch (tag 0) counts toward starvation: 1, then dcache 2,3,4
        tbl[11] = '{1'b1, 32'h108, 1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 0,   1'b1, 1'b0, MEM_LOAD,  32'h108, 64'h0,     0, 0, 0, 0};
        for (int i = 12; i <= 14; i++)
            tbl[i] = '{1'b1, 32'h500, 1'b1, MEM_STORE, 32'h400, 64'h77, 1'b0, 6, 0, 1'b0, 1'b1, MEM_STORE, 32'h400, 64'h77, 0, 6, 0, 0};
        tbl[15] = '{1'b1, 32'h500, 1'b1, MEM_STORE, 32'h400, 64'h77,    1'b0, 12, 0,  1'b1, 1'b0, MEM_LOAD,  32'h500, 64'h0,     12, 0, 0, 0};
        tbl[16] = '{1'b1, 32'h500, 1'b1, MEM_STORE, 32'h400, 64'h77,    1'b0, 13, 0,  1'b0, 1'b1, MEM_STORE, 32'h400, 64'h77,    0, 13, 0, 0};
        tbl[17] = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 12,  1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 12, 0};
        // plain starvation: dcache cycles 0-3, fetch cycle 4, dcache again
        for (int i = 18; i <= 21; i++)
            tbl[i] = '{1'b1, 32'h600, 1'b1, MEM_STORE, 32'h700, 64'h99, 1'b0, 6, 0, 1'b0, 1'b1, MEM_STORE, 32'h700, 64'h99, 0, 6, 0, 0};
        tbl[22] = '{1'b1, 32'h600, 1'b1, MEM_STORE, 32'h700, 64'h99,    1'b0, 12, 0,  1'b1, 1'b0, MEM_LOAD,  32'h600, 64'h0,     12, 0, 0, 0};
        tbl[23] = '{1'b1, 32'h600, 1'b1, MEM_STORE, 32'h700, 64'h99,    1'b0, 13, 0,  1'b0, 1'b1, MEM_STORE, 32'h700, 64'h99,    0, 13, 0, 0};
        tbl[24] = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 12,  1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 12, 0};
        tbl[25] = '{1'b0, 32'h0,   1'b0, MEM_NONE,  32'h0,   64'h0,     1'b0, 0, 4,   1'b0, 1'b0, MEM_NONE,  32'h0,   64'h0,     0, 0, 0, 0};

        // Reset: outputs during reset follow the inputs
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        step(idle, "rst");
        reset = 1'b0;

        for (int i = 0; i < NV; i++) step(tbl[i], $sformatf("v%0d", i));

        // Response in the flush cycle is still forwarded
        v = idle; v.fr = 1'b1; v.fa = 32'h120; v.tt = 1;
        v.efg = 1'b1; v.ecmd = MEM_LOAD; v.eaddr = 32'h120; v.eftt = 1;
        step(v, "A.alloc");
        v = idle; v.fl = 1'b1; v.dt = 1; v.efdt = 1;
        step(v, "A.flushresp");
        v = idle; v.dt = 1;
        step(v, "A.freed");

        // Fetch load accepted in the flush cycle is stale
        v = idle; v.fr = 1'b1; v.fa = 32'h124; v.fl = 1'b1; v.tt = 4;
        v.efg = 1'b1; v.ecmd = MEM_LOAD; v.eaddr = 32'h124; v.eftt = 4;
        step(v, "B.allocflush");
        v = idle; v.dt = 4;
        step(v, "B.stale");

        // Dcache entries survive a flush
        v = idle; v.dr = 1'b1; v.dcmd = MEM_LOAD; v.da = 32'h800; v.tt = 10;
        v.edg = 1'b1; v.ecmd = MEM_LOAD; v.eaddr = 32'h800; v.edtt = 10;
        step(v, "E.dcalloc");
        v = idle; v.fl = 1'b1;
        step(v, "E.flush");
        v = idle; v.dt = 10; v.eddt = 10;
        step(v, "E.dcresp");

        // Same-cycle response and reallocation of tag 9
        v = idle; v.dr = 1'b1; v.dcmd = MEM_LOAD; v.da = 32'h900; v.tt = 9;
        v.edg = 1'b1; v.ecmd = MEM_LOAD; v.eaddr = 32'h900; v.edtt = 9;
        step(v, "C.dcalloc");
        v = idle; v.fr = 1'b1; v.fa = 32'h130; v.tt = 9; v.dt = 9;
        v.efg = 1'b1; v.ecmd = MEM_LOAD; v.eaddr = 32'h130; v.eftt = 9; v.eddt = 9;
        step(v, "C.swap");
        v = idle; v.dt = 9; v.efdt = 9;
        step(v, "C.newowner");

        // Outstanding load dropped across reset
        v = idle; v.fr = 1'b1; v.fa = 32'h140; v.tt = 7;
        v.efg = 1'b1; v.ecmd = MEM_LOAD; v.eaddr = 32'h140; v.eftt = 7;
        step(v, "D.alloc");
        reset = 1'b1;
        step(idle, "D.reset");
        reset = 1'b0;
        v = idle; v.dt = 7;
        step(v, "D.dropped");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single processor-memory port between the instruction fetch unit and the data cache (load/store unit).
- Decides each cycle which requester drives the memory command, address and data, and hands the returned transaction tag back to that requester.
- Records which requester owns each outstanding load tag, so memory responses are steered back to the correct requester.
- Provides starvation protection for fetch and discards responses for fetch loads squashed by a branch.

Parameters:
- NUM_MEM_TAGS, `NUM_MEM_TAGS: number of memory tags. Tags are 1-based; tag 0 means none/reject.
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch gets priority.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fetch_req_en  in  1  fetch has a load request
- fetch_addr  in  ADDR  fetch load address
- dc_req_en  in  1  dcache has a request
- dc_command  in  MEM_COMMAND  MEM_LOAD or MEM_STORE
- dc_addr  in  ADDR  dcache address
- dc_store_data  in  MEM_BLOCK  store data
- fetch_flush  in  1  fetch squash; all fetch-owned outstanding tags become stale
- mem_transaction_tag  in  MEM_TAG  memory accept tag; 0 = rejected
- mem_data_tag  in  MEM_TAG  completed-transaction tag; 0 = none
- mem_data  in  MEM_BLOCK  load data from memory
- proc2mem_command  out  MEM_COMMAND  command to memory
- proc2mem_addr  out  ADDR  address to memory
- proc2mem_data  out  MEM_BLOCK  store data to memory
- fetch_grant  out  1  fetch owns the port this cycle (fetch's arbiter_signal)
- dc_grant  out  1  dcache owns the port this cycle
- fetch_transaction_tag  out  MEM_TAG  accept tag for fetch; 0 when not granted
- dc_transaction_tag  out  MEM_TAG  accept tag for dcache; 0 when not granted
- fetch_data_tag  out  MEM_TAG  response tag routed to fetch; 0 = none
- dc_data_tag  out  MEM_TAG  response tag routed to dcache; 0 = none
- resp_data  out  MEM_BLOCK  equals mem_data, shared by both requesters

Behaviour:
- Grant logic is combinational, same cycle as the request. At most one grant is high per cycle.
- Default priority is to the dcache. If starve_cnt >= STARVE_LIMIT and fetch_req_en is high, fetch wins.
- With no requests: both grants are 0, proc2mem_command = MEM_NONE, proc2mem_addr = 0, proc2mem_data = 0.
- Granted fetch: proc2mem_command = MEM_LOAD, proc2mem_addr = fetch_addr, proc2mem_data = 0.
- Granted dcache: proc2mem_command = dc_command, proc2mem_addr = dc_addr, proc2mem_data = dc_store_data.
- A request is accepted only when it is granted and mem_transaction_tag != 0. With tag 0 the grant is still visible, but the requester must retry; no state changes.
- starve_cnt is a saturating counter, width clog2(STARVE_LIMIT+1).
  - Increments in a cycle where fetch_req_en=1 and the fetch request is not accepted.
  - Clears when a fetch request is accepted, or when fetch_req_en=0.
- Ownership table, per tag t (1..NUM_MEM_TAGS), holds busy[t], owner[t] (0=fetch, 1=dcache) and stale[t].
  - On an accepted MEM_LOAD: busy[t] <= 1, owner[t] <= requester, stale[t] <= 0. Accepted stores allocate nothing.
- Response handling, when mem_data_tag = t != 0:
  - busy[t]=1, owner[t]=fetch, stale[t]=0: fetch_data_tag = t.
  - busy[t]=1, owner[t]=dcache: dc_data_tag = t.
  - busy[t]=1, stale[t]=1: the response is consumed silently; both data tags are 0.
  - In all three busy cases, busy[t] and stale[t] clear at the next edge.
  - busy[t]=0: the response is dropped and both data tags are 0.
- Same-cycle response and allocation of the same tag t: the response is routed using the old entry, and the new allocation wins in the next state.
- fetch_flush: at the edge, every busy entry with owner=fetch gets stale <= 1.
  - A fetch load accepted in the same cycle as the flush is also stale.
  - A response arriving in the flush cycle is still forwarded, since the flush takes effect at the edge.
  - starve_cnt clears on fetch_flush.
  - dcache entries are unaffected.
- Reset: busy, owner, stale and starve_cnt clear. Responses for pre-reset tags are then dropped. Combinational outputs follow the inputs.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds three 32-bit outputs:
  - fetch_grants_cnt: counts accepted fetch requests.
  - dc_grants_cnt: counts accepted dcache requests.
  - stale_drop_cnt: counts stale responses consumed.
- All three counters reset to 0 and wrap at 2^32.
- When not defined, these ports and counters do not exist, and the remaining behaviour is unchanged.

Test Plan:
- Fetch only, fetch_addr=0x100, mem_transaction_tag=3 → fetch_grant=1, MEM_LOAD to 0x100, fetch_transaction_tag=3. Later, mem_data_tag=3 → fetch_data_tag=3, dc_data_tag=0.
- Fetch and dcache both request, tags nonzero every cycle, STARVE_LIMIT=4 → dc_grant=1 for cycles 0-3, fetch_grant=1 in cycle 4, starve_cnt back to 0.
- Dcache MEM_STORE accepted with tag 5, then mem_data_tag=5 → dropped, both data tags 0.
- Fetch load accepted with tag 2, fetch_flush next cycle, then mem_data_tag=2 → fetch_data_tag=0. Tag 2 is freed, and a later dcache load on tag 2 is routed to dc_data_tag=2.
- Grant with mem_transaction_tag=0 → no allocation; a later mem_data_tag=that-slot is dropped; starve_cnt increments when the request was fetch.
- Load on tag 7 outstanding, reset asserted, then mem_data_tag=7 → both data tags 0.
